sparecell_lo_monitor: RTL and testbench
=======================================

Name: sparecell_lo_monitor

Overview:
- Readback and integrity checker for the tie-low outputs (LO) of a bank of spare-cell macros.
- Each spare-cell instance drives a constant-low LO net; this block is the receiving end of those nets.
- On request it synchronizes and captures all LO inputs, then shifts them out serially.
- It flags any LO observed high (tie-cell defect, bad ECO hookup) in a sticky error and a sticky per-cell fault map.
- Sits in the housekeeping/test area next to the spare-cell bank.

Parameters:
- NUM_CELLS, 8, number of monitored spare-cell LO inputs; legal range 1..32.
- CNT_W, 6, shift-counter width; must satisfy 2^CNT_W > NUM_CELLS.

Ports:
- wb_clk_i  input  1  system clock; all state on rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- lo_i  input  NUM_CELLS  LO outputs of the spare cells; asynchronous to wb_clk_i.
- start_i  input  1  request one capture/readback; level-sampled.
- err_clr_i  input  1  clears err_o and fault_map_o.
- busy_o  output  1  high while in SAMPLE or SHIFT.
- done_o  output  1  one-cycle pulse when readback completes.
- sdo_o  output  1  serial readback data, LSB (cell 0) first.
- sdo_valid_o  output  1  qualifies sdo_o.
- err_o  output  1  sticky: some LO was captured high.
- fault_map_o  output  NUM_CELLS  sticky per-cell OR of captured values.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0.
  - Synchronizers, shift register and counter cleared; state IDLE.
  - Reset mid-readback aborts it; no done_o is produced.
- Input sync: lo_i passes through a 2-flop synchronizer (lo_sync); captured data is 2 cycles old.
- FSM states IDLE, SAMPLE, SHIFT, DONE:
  - IDLE: start_i=1 at an edge -> SAMPLE.
  - SAMPLE: one cycle.
    - Next edge loads shift_reg <= lo_sync and counter <= NUM_CELLS.
    - Same edge ORs lo_sync into fault_map.
    - If |lo_sync then err_o <= 1.
    - -> SHIFT.
  - SHIFT: sdo_valid_o=1, sdo_o=shift_reg[0].
    - Each edge shifts shift_reg right (MSB fill 0) and decrements counter.
    - When counter reaches 1 at an edge -> DONE.
    - Exactly NUM_CELLS valid bits are emitted.
  - DONE: done_o=1, busy_o=0, sdo_valid_o=0 for one cycle -> IDLE.
- Timing: start_i seen at edge E0 gives:
  - busy_o high from E0 to E(NUM_CELLS+1).
  - Bit k valid in the cycle after E(k+1).
  - done_o high in the cycle after E(NUM_CELLS+1).
  - A new start is accepted at E(NUM_CELLS+3) at the earliest.
- start_i in SAMPLE, SHIFT or DONE is ignored; it is not queued.
- err_clr_i: clears err_o and fault_map_o at the next edge in any state.
  - If err_clr_i coincides with a SAMPLE capture edge, the new capture wins: the result is the captured value, not 0.
- fault_map_o and err_o are never cleared by start_i, only by err_clr_i or reset.
- sdo_o is 0 whenever sdo_valid_o=0.
- NUM_CELLS=1: SHIFT lasts exactly one cycle.

Test Plan:
- Reset check: assert wb_rst_i mid-SHIFT (NUM_CELLS=8) -> busy_o, sdo_valid_o, err_o, done_o and fault_map_o go to 0 immediately; no done_o after release.
- Clean bank: lo_i=8'h00 held, pulse start_i -> 8 cycles of sdo_valid_o with sdo_o=0, then done_o one cycle, err_o=0, fault_map_o=8'h00.
- Single defect: lo_i=8'hA5 held, start -> sdo sequence 1,0,1,0,0,1,0,1.
  - Then err_o=1 and fault_map_o=8'hA5.
  - Second run with lo_i=8'h02 -> fault_map_o=8'hA7, err_o stays 1.
- Clear collision: fault_map_o=8'h01, lo_i=8'h10; assert err_clr_i on the SAMPLE capture edge -> fault_map_o=8'h10, err_o=1.
  - err_clr_i alone in IDLE -> 8'h00, err_o=0.
- Start while busy: pulse start_i during SHIFT and during DONE -> ignored, exactly one done_o.
  - Start at E(NUM_CELLS+3) -> accepted.
- Synchronizer latency: lo_i changes 8'h00 -> 8'hFF one cycle before the SAMPLE capture edge -> captured value 8'h00.
  - Change two cycles before -> 8'hFF.

Source files
------------

// File: rtl/sparecell_lo_monitor.sv
// rtl/sparecell_lo_monitor.sv - capture, serial readback and sticky fault map for spare-cell tie-low outputs
module sparecell_lo_monitor #(
  parameter int NUM_CELLS = 8,
  parameter int CNT_W     = 6
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_CELLS-1:0] lo_i,
  input  logic                 start_i,
  input  logic                 err_clr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sdo_o,
  output logic                 sdo_valid_o,
  output logic                 err_o,
  output logic [NUM_CELLS-1:0] fault_map_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_CELLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t               state;
  logic [NUM_CELLS-1:0] lo_meta;
  logic [NUM_CELLS-1:0] lo_sync;
  logic [NUM_CELLS-1:0] shift_reg;
  logic [NUM_CELLS-1:0] shift_next;
  logic [CNT_W-1:0]     cnt;

  // Next shift-register contents; its bit 0 is the next serial bit.
  assign shift_next = shift_reg >> 1;

  // Two-flop synchronizer: lo_i is asynchronous to the system clock.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lo_meta <= '0;
      lo_sync <= '0;
    end else begin
      lo_meta <= lo_i;
      lo_sync <= lo_meta;
    end
  end

  // Readback sequencer with registered outputs and sticky error tracking.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      shift_reg   <= '0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sdo_o       <= 1'b0;
      sdo_valid_o <= 1'b0;
      err_o       <= 1'b0;
      fault_map_o <= '0;
    end else begin
      done_o <= 1'b0;

      // Clear applies in any state; a coincident capture below overrides it.
      if (err_clr_i) begin
        err_o       <= 1'b0;
        fault_map_o <= '0;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= SAMPLE;
            busy_o <= 1'b1;
          end
        end

        SAMPLE: begin
          shift_reg   <= lo_sync;
          cnt         <= CNT_LOAD;
          fault_map_o <= (err_clr_i ? '0 : fault_map_o) | lo_sync;
          err_o       <= (err_clr_i ? 1'b0 : err_o) | (|lo_sync);
          sdo_o       <= lo_sync[0];
          sdo_valid_o <= 1'b1;
          state       <= SHIFT;
        end

        SHIFT: begin
          shift_reg <= shift_next;
          cnt       <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            sdo_o       <= 1'b0;
            sdo_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            sdo_o <= shift_next[0];
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparecell_lo_monitor.sv
// tb/tb_sparecell_lo_monitor.sv - self-checking bench for sparecell_lo_monitor
module tb_sparecell_lo_monitor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] lo_i = '0;
  logic         start_i = 1'b0;
  logic         err_clr_i = 1'b0;
  logic         busy_o, done_o, sdo_o, sdo_valid_o, err_o;
  logic [N-1:0] fault_map_o;

  int vectors = 0;
  int miscompares = 0;

  sparecell_lo_monitor #(.NUM_CELLS(N), .CNT_W(6)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .lo_i       (lo_i),
    .start_i    (start_i),
    .err_clr_i  (err_clr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sdo_o      (sdo_o),
    .sdo_valid_o(sdo_valid_o),
    .err_o      (err_o),
    .fault_map_o(fault_map_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic       clr;
    logic [7:0] exp_fm;
    logic       exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic hold_lo(input logic [7:0] v);
    lo_i = v;
    repeat (3) tick();
  endtask

  // One full readback with the lo value already settled; checks every cycle.
  task automatic run_check(input logic [7:0] exp_sdo, input logic [7:0] exp_fm, input logic exp_err);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("valid_in_sample", sdo_valid_o, 0);
    tick();
    for (int k = 0; k < N; k++) begin
      check("sdo_valid", sdo_valid_o, 1);
      check("sdo_bit", sdo_o, exp_sdo[k]);
      check("busy_shift", busy_o, 1);
      tick();
    end
    check("done_pulse", done_o, 1);
    check("busy_done", busy_o, 0);
    check("valid_done", sdo_valid_o, 0);
    check("sdo_idle", sdo_o, 0);
    check("fault_map", fault_map_o, exp_fm);
    check("err", err_o, exp_err);
    tick();
    check("done_one_cycle", done_o, 0);
  endtask

  // Reference model state for the random phase.
  logic [7:0] hist[0:1023];
  int         e_cnt;
  int         run_start;
  logic [7:0] m_cap;
  logic [7:0] m_fm;
  logic       m_err;

  initial begin
    int d;
    int dones;
    logic [7:0] lo_r;
    logic st, cl;

    tbl[0] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{8'hA5, 1'b0, 8'hA5, 1'b1};
    tbl[2] = '{8'h02, 1'b0, 8'hA7, 1'b1};
    tbl[3] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    tbl[4] = '{8'h80, 1'b0, 8'hBC, 1'b1};
    tbl[5] = '{8'h00, 1'b1, 8'h00, 1'b0};

    // Reset state
    repeat (2) tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", sdo_valid_o, 0);
    check("rst_sdo", sdo_o, 0);
    check("rst_err", err_o, 0);
    check("rst_fm", fault_map_o, 0);
    rst = 1'b0;
    tick();

    // Table-driven readbacks
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].clr) clear_errors();
      hold_lo(tbl[i].lo);
      run_check(tbl[i].lo, tbl[i].exp_fm, tbl[i].exp_err);
    end

    // Clear colliding with the capture edge: capture wins
    clear_errors();
    hold_lo(8'h01);
    run_check(8'h01, 8'h01, 1'b1);
    hold_lo(8'h10);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("collide_fm", fault_map_o, 8'h10);
    check("collide_err", err_o, 1);
    repeat (N + 2) tick();
    clear_errors();
    check("idle_clr_fm", fault_map_o, 8'h00);
    check("idle_clr_err", err_o, 0);

    // Start while busy is ignored; start at E(N+3) is accepted
    hold_lo(8'h00);
    start_i = 1'b1;
    tick();
    dones = 0;
    for (int c = 1; c <= N + 3; c++) begin
      start_i = (c == 3 || c == N + 2 || c == N + 3);
      tick();
      if (done_o) dones++;
      if (c == N + 2) check("busy_after_ignored", busy_o, 0);
    end
    start_i = 1'b0;
    check("single_done", dones, 1);
    check("restart_accepted", busy_o, 1);
    repeat (N + 3) tick();
    check("restart_idle", busy_o, 0);

    // Synchronizer latency: change one cycle before capture -> old value
    clear_errors();
    hold_lo(8'h00);
    lo_i = 8'hFF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("sync_late_fm", fault_map_o, 8'h00);
    repeat (N + 2) tick();
    // Change two cycles before capture -> new value
    hold_lo(8'h00);
    clear_errors();
    lo_i = 8'hFF;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("sync_early_fm", fault_map_o, 8'hFF);
    repeat (N + 2) tick();

    // Reset mid-shift aborts the readback
    hold_lo(8'hFF);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", sdo_valid_o, 0);
    check("arst_err", err_o, 0);
    check("arst_done", done_o, 0);
    check("arst_fm", fault_map_o, 0);
    tick();
    tick();
    rst = 1'b0;
    lo_i = '0;
    dones = 0;
    for (int c = 0; c < N + 4; c++) begin
      tick();
      if (done_o) dones++;
    end
    check("no_done_after_rst", dones, 0);

    // Randomized phase against a timeline model
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    e_cnt = 0;
    run_start = -100;
    m_cap = '0;
    m_fm = '0;
    m_err = 1'b0;
    for (int it = 0; it < 400; it++) begin
      lo_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      st = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 15) == 0);
      lo_i = lo_r;
      start_i = st;
      err_clr_i = cl;
      // model the edge about to occur
      if (e_cnt == run_start + 1) begin
        m_cap = (e_cnt >= 2) ? hist[e_cnt - 2] : 8'h00;
        m_fm = (cl ? 8'h00 : m_fm) | m_cap;
        m_err = (cl ? 1'b0 : m_err) | (m_cap != 0);
      end else if (cl) begin
        m_fm = 8'h00;
        m_err = 1'b0;
      end
      if (st && e_cnt >= run_start + N + 3) run_start = e_cnt;
      hist[e_cnt] = lo_r;
      d = e_cnt - run_start;
      e_cnt++;
      tick();
      check("rnd_busy", busy_o, (d >= 0 && d <= N));
      check("rnd_valid", sdo_valid_o, (d >= 1 && d <= N));
      check("rnd_sdo", sdo_o, (d >= 1 && d <= N) ? m_cap[d - 1] : 1'b0);
      check("rnd_done", done_o, (d == N + 1));
      check("rnd_err", err_o, m_err);
      check("rnd_fm", fault_map_o, m_fm);
    end
    start_i = 1'b0;
    err_clr_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
